matrix_uart_display: RTL and testbench
======================================

Name: matrix_uart_display

Overview:
Output-direction counterpart of the UART matrix input path. When the controller enables display, this block reads an m x n matrix from Matrix_storage starting at a base address. It formats the matrix as ASCII decimal text and transmits it over a UART TX line, using 8N1 framing at 115200 baud. Its read port feeds Storage_Mux through the display-address input, and it reports completion back to FSM_Controller.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz
BAUD_RATE, 115200, UART bit rate; bit period = CLK_FREQ/BAUD_RATE clocks (868)
MAX_DIM, 5, largest legal row or column count
RD_LAT, 1, storage read latency in clocks (address to valid data)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
w_en_display  in  1  level enable from FSM; starts a dump when seen high in IDLE
w_base_addr  in  8  storage address of element (0,0); sampled at start
i_dim_m  in  3  row count; sampled at start
i_dim_n  in  3  column count; sampled at start
o_disp_addr  out  8  storage read address, to Storage_Mux i_disp_addr
i_storage_rdata  in  32  storage read data; only bits [7:0] are used
uart_tx  out  1  serial output, idles high
w_disp_done  out  1  one-clock pulse when the dump has finished
o_busy  out  1  high from start until w_disp_done

Behaviour:
- Reset values: uart_tx=1, o_disp_addr=0, w_disp_done=0, o_busy=0, FSM=IDLE. Reset in mid-frame forces uart_tx high in the same cycle, because reset is asynchronous. No partial frame resumes after reset.
- Start: in IDLE with w_en_display=1, latch the base address and both dims, then set o_busy=1 on the next clock.
- Invalid dims (m or n equal to 0, or greater than MAX_DIM): send no bytes and pulse w_disp_done 2 clocks after start.
- FSM states:
  - IDLE
  - HDR: emit m as a digit, ' ', n as a digit, CR, LF
  - RD_ADDR: drive addr = base + r*n + c, mod 256 (wraps)
  - RD_WAIT: wait RD_LAT clocks, then latch rdata[7:0]
  - CONV: produce hundreds and tens digits by repeated subtraction of 100 and 10; units digit is the remainder
  - SEND_DIG
  - SEND_SEP
  - DONE: pulse w_disp_done and clear o_busy
  - HOLD: wait until w_en_display=0, then return to IDLE. This prevents re-triggering while the enable stays high.
- Digit format: suppress leading zeros. Value 0 prints as "0". Values range 0..255. Bits [31:8] are ignored.
- Separators: ' ' after each element except the last in a row. CR LF (0x0D 0x0A) after the last element of each row. No trailing space.
- Byte handshake to the TX sub-module is tx_start (1 clock), tx_data, tx_busy. A new byte is issued only when tx_busy=0. Bytes go out back-to-back with no gap beyond the stop bit.
- Frame: start bit 0, data bits LSB first, stop bit 1. Each bit lasts exactly CLK_FREQ/BAUD_RATE clocks.
- w_disp_done asserts 1 clock after the stop bit of the final LF completes.
- w_en_display dropping mid-dump is ignored; the dump runs to completion.
- o_disp_addr holds its last value when the block is not reading.

Decomposition:
- Shared package holds: the ASCII constants (SPACE 0x20, CR 0x0D, LF 0x0A, ZERO 0x30), the display FSM state encoding, and MAX_DIM.
- One sub-module, uart_tx_byte. It contains the baud counter and the 10-bit shift frame, with ports clk, rst, tx_start, tx_data[7:0], tx_busy, uart_tx.
- The top level contains the sequencer, the address generator and the binary-to-decimal converter.

Test Plan:
- 2x2 of value 1 at base 0 -> byte stream "2 2\r\n1 1\r\n1 1\r\n" (15 bytes); one w_disp_done pulse; addresses 0,1,2,3 in order.
- 1x4 with values 0, 7, 10, 255 at base 8 -> "1 4\r\n0 7 10 255\r\n"; rdata upper bits set to 0xFFFFFF ignored.
- Timing check: each serial bit measured at 8680 ns ±10 ns; uart_tx idle high before and after the dump.
- dims m=0, n=3 -> no start bit ever seen on uart_tx; w_disp_done pulses exactly once, 2 clocks after start.
- Base 254, 2x2 -> read addresses 254, 255, 0, 1.
- Hold w_en_display high for 3 dump durations -> exactly one dump. Lower then raise the enable -> a second identical dump.
- Assert rst during the third data bit of a byte -> uart_tx=1 immediately; o_busy=0 and w_disp_done=0. After release the block sits in IDLE, and the next enable produces a complete dump.

Source files
------------

// File: rtl/matrix_uart_display_pkg.sv
// Shared constants for the matrix display path: ASCII codes, FSM encoding, dimension limit.
package matrix_uart_display_pkg;

  localparam logic [2:0] MAX_DIM = 3'd5;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_HDR      = 4'd1;
  localparam logic [3:0] ST_RD_ADDR  = 4'd2;
  localparam logic [3:0] ST_RD_WAIT  = 4'd3;
  localparam logic [3:0] ST_CONV     = 4'd4;
  localparam logic [3:0] ST_SEND_DIG = 4'd5;
  localparam logic [3:0] ST_SEND_SEP = 4'd6;
  localparam logic [3:0] ST_DONE     = 4'd7;
  localparam logic [3:0] ST_HOLD     = 4'd8;

  function automatic logic dims_valid(input logic [2:0] m, input logic [2:0] n);
    return (m != 3'd0) && (n != 3'd0) && (m <= MAX_DIM) && (n <= MAX_DIM);
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter. tx_busy drops during the last stop-bit clock so the next
// byte's start bit follows the stop bit with no idle gap.
module uart_tx_byte #(
  parameter int BIT_CLKS = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       uart_tx
);

  localparam int CNT_W = $clog2(BIT_CLKS);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BIT_CLKS - 1);

  logic             active;
  logic [8:0]       shift_q;
  logic [3:0]       bit_cnt;
  logic [CNT_W-1:0] baud_cnt;

  assign tx_busy = active && !((bit_cnt == 4'd0) && (baud_cnt == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active   <= 1'b0;
      shift_q  <= 9'h1FF;
      bit_cnt  <= 4'd0;
      baud_cnt <= '0;
      uart_tx  <= 1'b1;
    end else if (tx_start && !tx_busy) begin
      active   <= 1'b1;
      uart_tx  <= 1'b0;
      shift_q  <= {1'b1, tx_data};
      bit_cnt  <= 4'd9;
      baud_cnt <= BAUD_LAST;
    end else if (active) begin
      if (baud_cnt != '0) begin
        baud_cnt <= baud_cnt - CNT_W'(1);
      end else if (bit_cnt == 4'd0) begin
        active  <= 1'b0;
        uart_tx <= 1'b1;
      end else begin
        uart_tx  <= shift_q[0];
        shift_q  <= {1'b1, shift_q[8:1]};
        bit_cnt  <= bit_cnt - 4'd1;
        baud_cnt <= BAUD_LAST;
      end
    end
  end

endmodule

// File: rtl/matrix_uart_display.sv
// Reads an m x n matrix from storage and prints it as decimal ASCII text over UART.
//   state    | meaning
//   IDLE     | waiting for w_en_display
//   HDR      | send "m n\r\n", or bail out to DONE on illegal dims
//   RD_ADDR  | drive o_disp_addr = base + element index
//   RD_WAIT  | wait for storage read latency, latch the byte
//   CONV     | binary to decimal by repeated subtraction
//   SEND_DIG | send the decimal digits, leading zeros suppressed
//   SEND_SEP | send ' ' between elements or CR LF at row end
//   DONE     | wait for the line to go idle, pulse w_disp_done
//   HOLD     | wait for w_en_display to drop before re-arming
module matrix_uart_display
  import matrix_uart_display_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int RD_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        w_en_display,
  input  logic [7:0]  w_base_addr,
  input  logic [2:0]  i_dim_m,
  input  logic [2:0]  i_dim_n,
  output logic [7:0]  o_disp_addr,
  input  logic [31:0] i_storage_rdata,
  output logic        uart_tx,
  output logic        w_disp_done,
  output logic        o_busy
);

  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT + 1) : 1;
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(RD_LAT);

  logic [3:0]       state;
  logic [7:0]       base_q;
  logic [2:0]       dim_m_q, dim_n_q;
  logic [2:0]       row_q, col_q;
  logic [7:0]       idx_q;
  logic [2:0]       hdr_idx;
  logic             lf_phase;
  logic [7:0]       val_q;
  logic [1:0]       hund_q;
  logic [3:0]       tens_q;
  logic [1:0]       dig_sel;
  logic [LAT_W-1:0] wait_cnt;

  logic       tx_start, tx_busy;
  logic [7:0] tx_data;
  logic       dims_ok, last_col, last_row;
  logic       unused_rdata_hi;

  assign dims_ok         = dims_valid(dim_m_q, dim_n_q);
  assign last_col        = (col_q + 3'd1) == dim_n_q;
  assign last_row        = (row_q + 3'd1) == dim_m_q;
  assign unused_rdata_hi = ^i_storage_rdata[31:8];

  // Byte source for the transmitter; a byte is handed over in the cycle tx_start is high.
  always_comb begin
    tx_start = 1'b0;
    tx_data  = ASCII_SPACE;
    case (state)
      ST_HDR: begin
        tx_start = dims_ok && !tx_busy;
        case (hdr_idx)
          3'd0:    tx_data = ASCII_ZERO + {5'd0, dim_m_q};
          3'd1:    tx_data = ASCII_SPACE;
          3'd2:    tx_data = ASCII_ZERO + {5'd0, dim_n_q};
          3'd3:    tx_data = ASCII_CR;
          default: tx_data = ASCII_LF;
        endcase
      end
      ST_SEND_DIG: begin
        tx_start = !tx_busy;
        case (dig_sel)
          2'd0:    tx_data = ASCII_ZERO + {6'd0, hund_q};
          2'd1:    tx_data = ASCII_ZERO + {4'd0, tens_q};
          default: tx_data = ASCII_ZERO + val_q;
        endcase
      end
      ST_SEND_SEP: begin
        tx_start = !tx_busy;
        if (!last_col)      tx_data = ASCII_SPACE;
        else if (!lf_phase) tx_data = ASCII_CR;
        else                tx_data = ASCII_LF;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      base_q      <= 8'd0;
      dim_m_q     <= 3'd0;
      dim_n_q     <= 3'd0;
      row_q       <= 3'd0;
      col_q       <= 3'd0;
      idx_q       <= 8'd0;
      hdr_idx     <= 3'd0;
      lf_phase    <= 1'b0;
      val_q       <= 8'd0;
      hund_q      <= 2'd0;
      tens_q      <= 4'd0;
      dig_sel     <= 2'd0;
      wait_cnt    <= '0;
      o_disp_addr <= 8'd0;
      w_disp_done <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      w_disp_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (w_en_display) begin
            base_q  <= w_base_addr;
            dim_m_q <= i_dim_m;
            dim_n_q <= i_dim_n;
            hdr_idx <= 3'd0;
            o_busy  <= 1'b1;
            state   <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (!dims_ok) begin
            state <= ST_DONE;
          end else if (tx_start) begin
            if (hdr_idx == 3'd4) begin
              row_q <= 3'd0;
              col_q <= 3'd0;
              idx_q <= 8'd0;
              state <= ST_RD_ADDR;
            end else begin
              hdr_idx <= hdr_idx + 3'd1;
            end
          end
        end
        ST_RD_ADDR: begin
          o_disp_addr <= base_q + idx_q;
          wait_cnt    <= LAT_INIT;
          state       <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (wait_cnt == '0) begin
            val_q  <= i_storage_rdata[7:0];
            hund_q <= 2'd0;
            tens_q <= 4'd0;
            state  <= ST_CONV;
          end else begin
            wait_cnt <= wait_cnt - LAT_W'(1);
          end
        end
        ST_CONV: begin
          if (val_q >= 8'd100) begin
            val_q  <= val_q - 8'd100;
            hund_q <= hund_q + 2'd1;
          end else if (val_q >= 8'd10) begin
            val_q  <= val_q - 8'd10;
            tens_q <= tens_q + 4'd1;
          end else begin
            dig_sel <= (hund_q != 2'd0) ? 2'd0 : ((tens_q != 4'd0) ? 2'd1 : 2'd2);
            state   <= ST_SEND_DIG;
          end
        end
        ST_SEND_DIG: begin
          if (tx_start) begin
            if (dig_sel == 2'd2) begin
              lf_phase <= 1'b0;
              state    <= ST_SEND_SEP;
            end else begin
              dig_sel <= dig_sel + 2'd1;
            end
          end
        end
        ST_SEND_SEP: begin
          if (tx_start) begin
            if (!last_col) begin
              col_q <= col_q + 3'd1;
              idx_q <= idx_q + 8'd1;
              state <= ST_RD_ADDR;
            end else if (!lf_phase) begin
              lf_phase <= 1'b1;
            end else if (last_row) begin
              state <= ST_DONE;
            end else begin
              row_q <= row_q + 3'd1;
              col_q <= 3'd0;
              idx_q <= idx_q + 8'd1;
              state <= ST_RD_ADDR;
            end
          end
        end
        ST_DONE: begin
          if (!tx_busy) begin
            w_disp_done <= 1'b1;
            o_busy      <= 1'b0;
            state       <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (!w_en_display) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  uart_tx_byte #(
    .BIT_CLKS(CLK_FREQ / BAUD_RATE)
  ) u_tx (
    .clk      (clk),
    .rst      (rst),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .uart_tx  (uart_tx)
  );

endmodule

// File: tb/tb_matrix_uart_display.sv
// Scoreboard bench: expected bytes/addresses are queued from a text-level model,
// independent monitors decode the UART line and the read address and compare.
module tb_matrix_uart_display;

  localparam int CLK_FREQ  = 800_000;
  localparam int BAUD_RATE = 100_000;
  localparam int BIT_CLKS  = CLK_FREQ / BAUD_RATE;
  localparam int CLK_P     = 10;
  localparam int BIT_T     = BIT_CLKS * CLK_P;
  localparam int BUDGET    = 20000;

  logic        clk = 1'b0;
  logic        rst;
  logic        w_en_display;
  logic [7:0]  w_base_addr;
  logic [2:0]  i_dim_m, i_dim_n;
  logic [7:0]  o_disp_addr;
  logic [31:0] i_storage_rdata;
  logic        uart_tx, w_disp_done, o_busy;

  matrix_uart_display #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE),
    .RD_LAT   (1)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .w_en_display    (w_en_display),
    .w_base_addr     (w_base_addr),
    .i_dim_m         (i_dim_m),
    .i_dim_n         (i_dim_n),
    .o_disp_addr     (o_disp_addr),
    .i_storage_rdata (i_storage_rdata),
    .uart_tx         (uart_tx),
    .w_disp_done     (w_disp_done),
    .o_busy          (o_busy)
  );

  always #(CLK_P/2) clk = ~clk;

  logic [31:0] mem [256];
  initial begin
    i_storage_rdata = 32'd0;
    forever begin
      @(posedge clk);
      i_storage_rdata <= mem[o_disp_addr];
    end
  end

  logic [7:0] exp_q[$];
  logic [7:0] addr_q[$];
  int  n_pass = 0, n_total = 0;
  int  done_cnt = 0;
  time done_t = 0, last_t0 = 0;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  // Reference: the text a dump must produce and the addresses it must read.
  task automatic expect_dump(input logic [7:0] b, input int m, input int n);
    logic [7:0] a;
    if (m < 1 || m > 5 || n < 1 || n > 5) return;
    push_str($sformatf("%0d %0d", m, n));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    for (int r = 0; r < m; r++) begin
      for (int c = 0; c < n; c++) begin
        a = 8'((int'(b) + r * n + c) % 256);
        addr_q.push_back(a);
        push_str($sformatf("%0d", mem[a][7:0]));
        if (c < n - 1) exp_q.push_back(8'h20);
        else begin
          exp_q.push_back(8'h0D);
          exp_q.push_back(8'h0A);
        end
      end
    end
    if (addr_q.size() > 0 && addr_q[0] == o_disp_addr) void'(addr_q.pop_front());
  endtask

  // UART receiver: samples mid-bit, checks start-bit edge timing and byte spacing.
  initial begin : rx_mon
    logic [7:0] d, e;
    logic sb, pb, pre, post, hit;
    time t0, prev_t0;
    prev_t0 = 0;
    forever begin
      @(negedge uart_tx);
      if (rst) continue;
      t0 = $time;
      hit = 1'b0;
      #(BIT_T/2);       sb = uart_tx;  hit |= rst;
      #(BIT_T/2 - 1);   pre = uart_tx;
      #2;               post = uart_tx;
      #(BIT_T/2 - 1);   d[0] = uart_tx; hit |= rst;
      for (int i = 1; i < 8; i++) begin
        #(BIT_T); d[i] = uart_tx; hit |= rst;
      end
      #(BIT_T); pb = uart_tx; hit |= rst;
      if (hit) continue;
      chk(sb == 1'b0 && pb == 1'b1, "frame_start_stop", {sb, pb}, 1);
      if (exp_q.size() == 0) chk(1'b0, "unexpected_byte", d, 0);
      else begin
        e = exp_q.pop_front();
        chk(d == e, "tx_byte", d, e);
      end
      if (d[0]) chk(pre == 1'b0 && post == 1'b1, "start_bit_width", {pre, post}, 1);
      if (prev_t0 != 0 && (t0 - prev_t0) < 15 * BIT_T)
        chk((t0 - prev_t0) == 10 * BIT_T, "byte_spacing", t0 - prev_t0, 10 * BIT_T);
      prev_t0 = t0;
      last_t0 = t0;
    end
  end

  initial begin : addr_mon
    logic [7:0] prev, e;
    prev = 8'd0;
    forever begin
      @(negedge clk);
      if (rst) prev = o_disp_addr;
      else if (o_disp_addr !== prev) begin
        if (addr_q.size() == 0) chk(1'b0, "unexpected_addr", o_disp_addr, 0);
        else begin
          e = addr_q.pop_front();
          chk(o_disp_addr == e, "read_addr", o_disp_addr, e);
        end
        prev = o_disp_addr;
      end
    end
  end

  initial begin : done_mon
    forever begin
      @(negedge clk);
      if (!rst && w_disp_done) done_cnt++;
    end
  end

  initial begin : done_time_mon
    forever begin
      @(posedge w_disp_done);
      done_t = $time;
    end
  end

  task automatic gap();
    repeat (6 * BIT_CLKS) @(negedge clk);
  endtask

  task automatic run_dump(input logic [7:0] b, input int m, input int n,
                          input bit hold_en, output int cycles);
    int d0;
    bit got, valid;
    valid = (m >= 1 && m <= 5 && n >= 1 && n <= 5);
    expect_dump(b, m, n);
    d0 = done_cnt;
    @(negedge clk);
    chk(uart_tx == 1'b1, "idle_before", uart_tx, 1);
    w_base_addr  = b;
    i_dim_m      = m[2:0];
    i_dim_n      = n[2:0];
    w_en_display = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk(o_busy == 1'b1, "busy_after_start", o_busy, 1);
    if (!hold_en) w_en_display = 1'b0;
    cycles = 0;
    got = 1'b0;
    for (int k = 0; k < BUDGET; k++) begin
      if (w_disp_done) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      cycles++;
      @(negedge clk);
    end
    chk(got, "done_seen", got, 1);
    if (valid)
      chk(done_t >= last_t0 + 10 * BIT_T && done_t <= last_t0 + 10 * BIT_T + 2 * CLK_P,
          "done_after_stop", done_t - last_t0, 10 * BIT_T);
    @(negedge clk);
    chk(w_disp_done == 1'b0 && o_busy == 1'b0, "done_pulse_end", {w_disp_done, o_busy}, 0);
    chk(done_cnt - d0 == 1, "done_count", done_cnt - d0, 1);
    chk(exp_q.size() == 0, "bytes_missing", exp_q.size(), 0);
    chk(addr_q.size() == 0, "addrs_missing", addr_q.size(), 0);
    chk(uart_tx == 1'b1, "idle_after", uart_tx, 1);
  endtask

  initial begin : main
    int cyc, cyc2, d;
    bit got;
    rst = 1'b1;
    w_en_display = 1'b0;
    w_base_addr = 8'd0;
    i_dim_m = 3'd0;
    i_dim_n = 3'd0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    repeat (3) @(negedge clk);
    chk(uart_tx == 1'b1, "rst_uart_tx", uart_tx, 1);
    chk(o_disp_addr == 8'd0, "rst_addr", o_disp_addr, 0);
    chk(w_disp_done == 1'b0, "rst_done", w_disp_done, 0);
    chk(o_busy == 1'b0, "rst_busy", o_busy, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 4; i++) mem[i] = 32'h1;
    run_dump(8'd0, 2, 2, 1'b0, cyc);
    gap();

    mem[8] = 32'hFFFFFF00; mem[9]  = 32'hFFFFFF07;
    mem[10] = 32'hFFFFFF0A; mem[11] = 32'hFFFFFFFF;
    run_dump(8'd8, 1, 4, 1'b0, cyc);
    gap();

    run_dump(8'd5, 0, 3, 1'b0, cyc);
    chk(cyc == 2, "invalid_done_latency", cyc, 2);
    gap();
    run_dump(8'd5, 6, 2, 1'b0, cyc);
    chk(cyc == 2, "invalid_done_latency_big", cyc, 2);
    gap();

    run_dump(8'd254, 2, 2, 1'b0, cyc);
    gap();

    // Enable held high: exactly one dump, then re-arm by toggling.
    run_dump(8'd40, 2, 2, 1'b1, cyc);
    d = done_cnt;
    repeat (2 * cyc) @(negedge clk);
    chk(done_cnt == d, "hold_no_retrigger", done_cnt - d, 0);
    chk(o_busy == 1'b0 && uart_tx == 1'b1, "hold_quiet", {o_busy, uart_tx}, 1);
    w_en_display = 1'b0;
    gap();
    run_dump(8'd40, 2, 2, 1'b0, cyc2);
    chk(cyc2 == cyc, "second_dump_length", cyc2, cyc);
    gap();

    // Reset during the third data bit of the first byte.
    expect_dump(8'd60, 2, 3);
    @(negedge clk);
    w_base_addr = 8'd60;
    i_dim_m = 3'd2;
    i_dim_n = 3'd3;
    w_en_display = 1'b1;
    got = 1'b0;
    for (int k = 0; k < BUDGET; k++) begin
      @(negedge clk);
      if (uart_tx == 1'b0) begin
        got = 1'b1;
        break;
      end
    end
    chk(got, "rst_test_start_bit", got, 1);
    #(3 * BIT_T + BIT_T/2 - CLK_P/2 + 10);
    rst = 1'b1;
    #1;
    chk(uart_tx == 1'b1, "rst_mid_uart_tx", uart_tx, 1);
    chk(o_busy == 1'b0, "rst_mid_busy", o_busy, 0);
    chk(w_disp_done == 1'b0, "rst_mid_done", w_disp_done, 0);
    w_en_display = 1'b0;
    exp_q.delete();
    addr_q.delete();
    repeat (10) @(negedge clk);
    rst = 1'b0;
    repeat (20 * BIT_CLKS) @(negedge clk);
    chk(o_busy == 1'b0 && uart_tx == 1'b1, "idle_after_reset", {o_busy, uart_tx}, 1);
    run_dump(8'd60, 2, 3, 1'b0, cyc);
    gap();

    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      run_dump(8'($urandom_range(0, 255)), int'($urandom_range(1, 5)),
               int'($urandom_range(1, 5)), 1'b0, cyc);
      gap();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
